bram_tdp_be: RTL and testbench

Parametrised true-dual-port block RAM with per-lane byte enables, per-port read mode, deterministic same-cycle collision rules, and a hardware clear sequencer that zero-fills (or CLR_VAL-fills) the array after reset. It is the next-generation shared memory for the yarvi core complex. It replaces fixed-width dual-port instances where both ports share one clock and software must see a known memory image after reset.

---
 rtl/bram_tdp_be_if.sv | 45 ++++
 rtl/bram_tdp_be.sv | 96 +++++++++
 tb/tb_bram_tdp_be.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/bram_tdp_be_if.sv
// Bus bundle for the true-dual-port byte-enable RAM: the two request ports,
// their registered responses, and the ready flag from the clear sequencer.
interface bram_tdp_be_if #(
    parameter int DATA_W = 72,
    parameter int ADDR_W = 10,
    parameter int LANE_W = 8
);
    localparam int NLANE = DATA_W / LANE_W;

    logic              ready;

    logic              a_en;
    logic              a_wr;
    logic [NLANE-1:0]  a_be;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_din;
    logic [DATA_W-1:0] a_dout;
    logic              a_vld;

    logic              b_en;
    logic              b_wr;
    logic [NLANE-1:0]  b_be;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_din;
    logic [DATA_W-1:0] b_dout;
    logic              b_vld;

    // Requester side: issues commands, receives responses.
    modport master (
        input  ready,
        output a_en, a_wr, a_be, a_addr, a_din,
        input  a_dout, a_vld,
        output b_en, b_wr, b_be, b_addr, b_din,
        input  b_dout, b_vld
    );

    // Memory side: accepts commands, drives responses.
    modport slave (
        output ready,
        input  a_en, a_wr, a_be, a_addr, a_din,
        output a_dout, a_vld,
        input  b_en, b_wr, b_be, b_addr, b_din,
        output b_dout, b_vld
    );
endinterface

// File: rtl/bram_tdp_be.sv
// True-dual-port RAM with per-lane byte enables, per-port read-first or
// write-first response, A-wins-per-lane collision resolution, and a clear
// sequencer that fills every word with CLR_VAL after reset before accepting
// any request. DATA_W must be an integer multiple of LANE_W.
module bram_tdp_be #(
    parameter int                DATA_W  = 72,
    parameter int                ADDR_W  = 10,
    parameter int                LANE_W  = 8,
    parameter int                A_MODE  = 0,
    parameter int                B_MODE  = 0,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    bram_tdp_be_if.slave   bus
);
    localparam int NLANE = DATA_W / LANE_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [DATA_W-1:0] a_old, a_merge;
    logic [DATA_W-1:0] b_old, b_merge;
    logic              a_we, b_we;

    // Requests only take effect in RUN and never on a reset edge.
    assign a_we = rst_n && (state == RUN) && bus.a_en && bus.a_wr;
    assign b_we = rst_n && (state == RUN) && bus.b_en && bus.b_wr;

    // Pre-cycle word per port, and that word merged with the port's own lane writes.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        a_old   = mem[bus.a_addr];
        b_old   = mem[bus.b_addr];
        a_merge = a_old;
        b_merge = b_old;
        for (int i = 0; i < NLANE; i++) begin
            if (bus.a_wr && bus.a_be[i]) a_merge[i*LANE_W +: LANE_W] = bus.a_din[i*LANE_W +: LANE_W];
            if (bus.b_wr && bus.b_be[i]) b_merge[i*LANE_W +: LANE_W] = bus.b_din[i*LANE_W +: LANE_W];
        end
    end

    // Array update: clear fill, then per-lane port writes with A applied last so A wins a shared lane.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch; the clear sequencer initialises it so it can map to block RAM.
        if (rst_n) begin
            if (state == CLEAR) begin
                mem[clr_cnt] <= CLR_VAL;
            end else begin
                for (int i = 0; i < NLANE; i++) begin
                    if (b_we && bus.b_be[i]) mem[bus.b_addr][i*LANE_W +: LANE_W] <= bus.b_din[i*LANE_W +: LANE_W];
                end
                for (int i = 0; i < NLANE; i++) begin
                    if (a_we && bus.a_be[i]) mem[bus.a_addr][i*LANE_W +: LANE_W] <= bus.a_din[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Sequencer FSM with registered ready and per-port response registers.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every reader sees the pre-edge value.
        if (!rst_n) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            bus.ready  <= 1'b0;
            bus.a_dout <= '0;
            bus.b_dout <= '0;
            bus.a_vld  <= 1'b0;
            bus.b_vld  <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    bus.a_vld <= 1'b0;
                    bus.b_vld <= 1'b0;
                    if (clr_cnt == '1) begin
                        state     <= RUN;
                        bus.ready <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                RUN: begin
                    bus.a_vld <= bus.a_en;
                    bus.b_vld <= bus.b_en;
                    if (bus.a_en) bus.a_dout <= (A_MODE == 1) ? a_merge : a_old;
                    if (bus.b_en) bus.b_dout <= (B_MODE == 1) ? b_merge : b_old;
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_tdp_be.sv
// Self-checking bench for bram_tdp_be: port A read-first, port B write-first,
// 16-word array. A reference memory produces expected responses which are
// queued at issue time and popped when the response cycle arrives.
module tb_bram_tdp_be;
    localparam int DW = 72;
    localparam int AW = 4;
    localparam int LW = 8;
    localparam int NL = DW / LW;
    localparam int DEPTH = 2**AW;
    localparam int AM = 0;
    localparam int BM = 1;

    typedef struct {
        logic          vld;
        logic [DW-1:0] dout;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    bram_tdp_be_if #(.DATA_W(DW), .ADDR_W(AW), .LANE_W(LW)) bus ();

    bram_tdp_be #(
        .DATA_W(DW), .ADDR_W(AW), .LANE_W(LW),
        .A_MODE(AM), .B_MODE(BM), .CLR_VAL(72'h0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] last_a, last_b;
    exp_t          qa[$], qb[$];
    int            n_pass = 0;
    int            n_total = 0;

    function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old, input logic [DW-1:0] din,
                                                 input logic [NL-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < NL; i++) if (be[i]) r[i*LW +: LW] = din[i*LW +: LW];
        return r;
    endfunction

    task automatic idle_inputs();
        bus.a_en = 0; bus.a_wr = 0; bus.a_be = '0; bus.a_addr = '0; bus.a_din = '0;
        bus.b_en = 0; bus.b_wr = 0; bus.b_be = '0; bus.b_addr = '0; bus.b_din = '0;
    endtask

    // One RUN cycle on both ports: queue expectations, drive, advance, pop and compare.
    task automatic issue(input logic ae, input logic aw, input logic [NL-1:0] abe, input logic [AW-1:0] aa,
                         input logic [DW-1:0] ad,
                         input logic be_, input logic bw, input logic [NL-1:0] bbe, input logic [AW-1:0] ba,
                         input logic [DW-1:0] bd, input string tag);
        logic [DW-1:0] old_a, old_b;
        exp_t ea, eb;
        old_a = model[aa];
        old_b = model[ba];
        if (ae) last_a = (AM == 1 && aw) ? lane_merge(old_a, ad, abe) : old_a;
        if (be_) last_b = (BM == 1 && bw) ? lane_merge(old_b, bd, bbe) : old_b;
        qa.push_back('{ae, last_a});
        qb.push_back('{be_, last_b});
        if (be_ && bw) model[ba] = lane_merge(model[ba], bd, bbe);
        if (ae && aw)  model[aa] = lane_merge(model[aa], ad, abe);

        bus.a_en = ae; bus.a_wr = aw; bus.a_be = abe; bus.a_addr = aa; bus.a_din = ad;
        bus.b_en = be_; bus.b_wr = bw; bus.b_be = bbe; bus.b_addr = ba; bus.b_din = bd;
        @(posedge clk);
        @(negedge clk);
        ea = qa.pop_front();
        eb = qb.pop_front();
        n_total++;
        if (bus.a_vld !== ea.vld || bus.a_dout !== ea.dout)
            $display("FAIL %s port A: got vld=%0b dout=%h, want vld=%0b dout=%h", tag, bus.a_vld, bus.a_dout, ea.vld, ea.dout);
        else n_pass++;
        n_total++;
        if (bus.b_vld !== eb.vld || bus.b_dout !== eb.dout)
            $display("FAIL %s port B: got vld=%0b dout=%h, want vld=%0b dout=%h", tag, bus.b_vld, bus.b_dout, eb.vld, eb.dout);
        else n_pass++;
        idle_inputs();
    endtask

    // Releases reset at a negedge and counts edges until ready, watching for stray responses.
    task automatic run_clear(input string tag, input int want_edges);
        int  edges = 0;
        bit  quiet = 1;
        rst_n = 1;
        while (!bus.ready && edges < 40) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
            if (bus.a_vld !== 1'b0 || bus.b_vld !== 1'b0 || bus.a_dout !== '0 || bus.b_dout !== '0) quiet = 0;
        end
        idle_inputs();
        n_total++;
        if (bus.ready !== 1'b1 || edges != want_edges)
            $display("FAIL %s ready edges: got %0d (ready=%0b), want %0d", tag, edges, bus.ready, want_edges);
        else n_pass++;
        n_total++;
        if (!quiet) $display("FAIL %s outputs during clear: got activity, want vld=0 dout=0", tag);
        else n_pass++;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        last_a = '0;
        last_b = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_total++;
        if (bus.ready !== 1'b0 || bus.a_vld !== 1'b0 || bus.b_vld !== 1'b0 || bus.a_dout !== '0 || bus.b_dout !== '0)
            $display("FAIL %s: got ready=%0b a_vld=%0b b_vld=%0b a_dout=%h b_dout=%h, want all 0",
                     tag, bus.ready, bus.a_vld, bus.b_vld, bus.a_dout, bus.b_dout);
        else n_pass++;
    endtask

    // Reset state and full clear with a write request held on port A the whole time.
    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        bus.a_en = 1; bus.a_wr = 1; bus.a_be = '1; bus.a_din = '1; bus.a_addr = 4'd2;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        run_clear("clear", DEPTH);
    endtask

    task automatic test_clear_contents();
        for (int i = 0; i < DEPTH; i++)
            issue(1, 0, '0, AW'(i), '0, 1, 0, '0, AW'(DEPTH-1-i), '0, "clear_read");
    endtask

    task automatic test_byte_enables();
        issue(1, 1, 9'h1FF, 4'd3, 72'hFF_FFFF_FFFF_FFFF_FFFF, 0, 0, '0, '0, '0, "be_full_write");
        issue(1, 1, 9'h001, 4'd3, 72'h0, 0, 0, '0, '0, '0, "be_lane0_write");
        n_total++;
        if (bus.a_dout !== 72'hFF_FFFF_FFFF_FFFF_FFFF)
            $display("FAIL be_old_word: got %h, want %h", bus.a_dout, 72'hFF_FFFF_FFFF_FFFF_FFFF);
        else n_pass++;
        issue(1, 0, '0, 4'd3, '0, 0, 0, '0, '0, '0, "be_readback");
        n_total++;
        if (bus.a_dout !== 72'hFF_FFFF_FFFF_FFFF_FF00)
            $display("FAIL be_merged: got %h, want %h", bus.a_dout, 72'hFF_FFFF_FFFF_FFFF_FF00);
        else n_pass++;
    endtask

    task automatic test_write_first();
        issue(0, 0, '0, '0, '0, 1, 1, 9'h001, 4'd5, 72'h12, "wf_write");
        n_total++;
        if (bus.b_vld !== 1'b1 || bus.b_dout !== 72'h12)
            $display("FAIL wf_dout: got vld=%0b dout=%h, want vld=1 dout=%h", bus.b_vld, bus.b_dout, 72'h12);
        else n_pass++;
        // Zero byte enable: nothing written, response is the stored word.
        issue(0, 0, '0, '0, '0, 1, 1, 9'h000, 4'd3, 72'h1234, "wf_zero_be");
        issue(1, 0, '0, 4'd3, '0, 0, 0, '0, '0, '0, "wf_zero_be_readback");
    endtask

    task automatic test_collision();
        issue(1, 1, 9'h001, 4'd7, 72'hAAAA, 1, 1, 9'h003, 4'd7, 72'hBBBB, "coll_write");
        issue(1, 0, '0, 4'd7, '0, 1, 0, '0, 4'd7, '0, "coll_read");
        n_total++;
        if (bus.a_dout !== 72'hBBAA) $display("FAIL coll_lanes: got %h, want %h", bus.a_dout, 72'hBBAA);
        else n_pass++;
    endtask

    task automatic test_cross_port();
        issue(1, 1, 9'h001, 4'd9, 72'h55, 1, 0, '0, 4'd9, '0, "xport_same_cycle");
        n_total++;
        if (bus.b_dout !== 72'h0) $display("FAIL xport_old: got %h, want %h", bus.b_dout, 72'h0);
        else n_pass++;
        issue(0, 0, '0, '0, '0, 1, 0, '0, 4'd9, '0, "xport_next");
        n_total++;
        if (bus.b_dout !== 72'h55) $display("FAIL xport_new: got %h, want %h", bus.b_dout, 72'h55);
        else n_pass++;
    endtask

    task automatic test_idle_hold();
        issue(0, 1, '1, 4'd1, '1, 0, 1, '1, 4'd2, '1, "idle_hold");
        issue(1, 0, '0, 4'd1, '0, 1, 0, '0, 4'd2, '0, "idle_no_write");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 60; n++) begin
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), NL'($urandom), AW'($urandom), {$urandom, $urandom, $urandom},
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), NL'($urandom), AW'($urandom), {$urandom, $urandom, $urandom},
                  "b2b_random");
        end
    endtask

    task automatic test_mid_clear_reset();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        repeat (8) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        check_reset_outputs("midclear_reset_state");
        run_clear("midclear", DEPTH);
        issue(1, 0, '0, 4'd7, '0, 1, 0, '0, 4'd9, '0, "midclear_zeroed");
    endtask

    initial begin
        test_reset();
        test_clear_contents();
        test_byte_enables();
        test_write_first();
        test_collision();
        test_cross_port();
        test_idle_hold();
        test_back_to_back();
        test_mid_clear_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
